// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared states, bus-level constants and default address for the
//            I2C temperature responder.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  localparam logic       c_ACK          = 1'b0;
  localparam logic       c_NACK         = 1'b1;
  localparam logic [6:0] c_DEFAULT_ADDR = 7'h4B;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Brief    : SCL/SDA synchronizers plus START, STOP and SCL edge detection.
// Revision : 1.0
// ============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus level is high, so reset to 1 to avoid phantom edges on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= i_scl;
      r_sda_sync[0] <= i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_start    = w_scl &  r_sda_d & ~w_sda;
  assign o_stop     = w_scl & ~r_sda_d &  w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;

endmodule
`default_nettype wire

// File: rtl/i2c_temp_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_temp_responder
// Brief    : I2C target exposing a 16-bit temperature word as two registers.
// Revision : 1.0
// ============================================================================
module i2c_temp_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = c_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  output logic        busy,
  output logic        ptr_wr,
  output logic        rd_byte_done
);

  logic w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk        (sys_clk),
    .rst_n      (sys_rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall)
  );

  state_e      r_state, w_state_nx;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic [15:0] r_hold, w_hold_nx;
  logic        r_ptr, w_ptr_nx;
  logic        r_rw, w_rw_nx;
  logic        r_first, w_first_nx;
  logic        r_sda_oe, w_sda_oe_nx;
  logic        r_ptr_wr, w_ptr_wr_nx;
  logic        r_rd_done, w_rd_done_nx;
  logic [7:0]  w_sel_byte;
  logic        w_addr_match;

  assign w_sel_byte   = r_ptr ? r_hold[7:0] : r_hold[15:8];
  assign w_addr_match = (r_shift[6:0] == DEV_ADDR);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  // STOP outranks START, and both outrank any SCL edge seen in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    if (w_stop) begin
      w_state_nx = ST_IDLE;
    end else if (w_start) begin
      w_state_nx = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR:
          if (w_scl_rise && r_bit_cnt == 4'd7)
            w_state_nx = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:
          if (w_scl_fall && r_bit_cnt != 4'd0)
            w_state_nx = r_rw ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:
          if (w_scl_rise && r_bit_cnt == 4'd7) w_state_nx = ST_WR_ACK;
        ST_WR_ACK:
          if (w_scl_fall && r_bit_cnt != 4'd0) w_state_nx = ST_WR_BYTE;
        ST_RD_BYTE:
          if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nx = ST_RD_ACK;
        ST_RD_ACK:
          if (w_scl_rise) w_state_nx = (w_sda == c_NACK) ? ST_WAIT_STOP : ST_RD_BYTE;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state != ST_IDLE);
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_hold_nx    = r_hold;
    w_ptr_nx     = r_ptr;
    w_rw_nx      = r_rw;
    w_first_nx   = r_first;
    w_sda_oe_nx  = r_sda_oe;
    w_ptr_wr_nx  = 1'b0;
    w_rd_done_nx = 1'b0;
    if (w_stop || w_start) begin
      w_sda_oe_nx  = 1'b0;
      w_bit_cnt_nx = '0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx   = {r_shift[6:0], w_sda};
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nx = '0;
              if (w_addr_match) begin
                w_rw_nx    = w_sda;
                w_first_nx = ~w_sda;
                if (w_sda) w_hold_nx = temp_value;
              end
            end
          end
        end
        // Ack slots: bit counter 0 = waiting to drive, 1 = master has clocked it.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (w_scl_rise) begin
            w_bit_cnt_nx = 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd0) begin
              w_sda_oe_nx = ~c_ACK;
            end else begin
              w_bit_cnt_nx = '0;
              w_sda_oe_nx  = 1'b0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_sda_oe_nx = ~w_sel_byte[7];
                w_shift_nx  = {w_sel_byte[6:0], 1'b0};
              end
            end
          end
        end
        ST_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nx   = {r_shift[6:0], w_sda};
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nx = '0;
              if (r_first) begin
                w_ptr_nx    = w_sda;
                w_ptr_wr_nx = 1'b1;
                w_first_nx  = 1'b0;
              end
            end
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_rise) begin
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd0) begin
              w_sda_oe_nx = ~w_sel_byte[7];
              w_shift_nx  = {w_sel_byte[6:0], 1'b0};
            end else if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nx  = 1'b0;
              w_bit_cnt_nx = '0;
            end else begin
              w_sda_oe_nx = ~r_shift[7];
              w_shift_nx  = {r_shift[6:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            w_rd_done_nx = 1'b1;
            w_ptr_nx     = ~r_ptr;
            w_bit_cnt_nx = '0;
          end
        end
        default: w_sda_oe_nx = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_hold    <= '0;
      r_ptr     <= 1'b0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_ptr_wr  <= 1'b0;
      r_rd_done <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nx;
      r_shift   <= w_shift_nx;
      r_hold    <= w_hold_nx;
      r_ptr     <= w_ptr_nx;
      r_rw      <= w_rw_nx;
      r_first   <= w_first_nx;
      r_sda_oe  <= w_sda_oe_nx;
      r_ptr_wr  <= w_ptr_wr_nx;
      r_rd_done <= w_rd_done_nx;
    end
  end

  // Masking with STOP lets the pin let go in the detection cycle itself.
  assign sda_oe       = r_sda_oe & ~w_stop;
  assign ptr_wr       = r_ptr_wr;
  assign rd_byte_done = r_rd_done;

endmodule
`default_nettype wire

// File: tb/tb_i2c_temp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_temp_responder
// Brief    : Bit-banged I2C master with a bus monitor feeding a byte scoreboard.
// Revision : 1.0
// ============================================================================
module tb_i2c_temp_responder;

  localparam int Q = 250;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        m_scl   = 1'b1;
  logic        m_sda   = 1'b1;
  logic [15:0] temp_value = 16'h1A80;
  logic        sda_oe, busy, ptr_wr, rd_byte_done;
  logic        sda_line;

  assign sda_line = m_sda & ~sda_oe;

  always #5 sys_clk = ~sys_clk;

  i2c_temp_responder #(
    .DEV_ADDR    (7'h4B),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .scl_in       (m_scl),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .temp_value   (temp_value),
    .busy         (busy),
    .ptr_wr       (ptr_wr),
    .rd_byte_done (rd_byte_done)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [8:0] exp_q[$];
  int         n_done  = 0;
  int         n_ptrwr = 0;
  int         n_oe    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge sys_clk) begin
    if (rd_byte_done) n_done++;
    if (ptr_wr) n_ptrwr++;
    if (sda_oe) n_oe++;
  end

  // Bus monitor: every 9th SCL rise after a START closes a {data, ack} token.
  int         mbits = 0;
  int         nbyte = 0;
  logic [8:0] msh   = '0;

  always @(posedge m_scl) begin
    msh = {msh[7:0], sda_line};
    mbits++;
    if (mbits == 9) begin
      mbits = 0;
      nbyte++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL bus byte %0d: got %0h, expected no byte", nbyte, msh);
      end else begin
        chk($sformatf("bus byte %0d {data,ack}", nbyte), 32'(msh), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge sda_line) if (m_scl === 1'b1) mbits = 0;

  task automatic send_bit(input logic b);
    m_sda = b;
    #Q m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1;
      #Q m_scl = 1'b1;
      #Q;
    end
    m_sda = 1'b0;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
    exp_q.push_back({b, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic rd_byte(input logic [7:0] exp_b, input logic m_ack);
    exp_q.push_back({exp_b, m_ack});
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(m_ack);
  endtask

  initial begin
    #1_500_000;
    n_total++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    int d_done, d_pw, d_oe;
    logic [7:0] abyte;
    #22;
    chk("reset sda_oe", 32'(sda_oe), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ptr_wr", 32'(ptr_wr), 0);
    chk("reset rd_byte_done", 32'(rd_byte_done), 0);
    #20 sys_rst = 1'b1;
    #200;

    // Plain two-byte read from pointer 0
    d_done = n_done; d_pw = n_ptrwr;
    i2c_start();
    wr_byte(8'h97, 1'b0);
    rd_byte(8'h1A, 1'b0);
    rd_byte(8'h80, 1'b1);
    i2c_stop();
    #500;
    chk("read rd_byte_done pulses", 32'(n_done - d_done), 2);
    chk("read ptr_wr pulses", 32'(n_ptrwr - d_pw), 0);
    chk("busy after stop", 32'(busy), 0);

    // Pointer write; the trailing 0x00 must be discarded
    d_pw = n_ptrwr;
    i2c_start();
    wr_byte(8'h96, 1'b0);
    wr_byte(8'h01, 1'b0);
    wr_byte(8'h00, 1'b0);
    i2c_stop();
    #500;
    chk("pointer write ptr_wr pulses", 32'(n_ptrwr - d_pw), 1);
    i2c_start();
    wr_byte(8'h97, 1'b0);
    rd_byte(8'h80, 1'b0);
    rd_byte(8'h1A, 1'b1);
    i2c_stop();

    // Pointer write then repeated START into a read
    i2c_start();
    wr_byte(8'h96, 1'b0);
    wr_byte(8'h00, 1'b0);
    i2c_start();
    wr_byte(8'h97, 1'b0);
    rd_byte(8'h1A, 1'b0);
    rd_byte(8'h80, 1'b1);
    i2c_stop();

    // temp_value changes mid-byte; bytes come from the snapshot
    i2c_start();
    wr_byte(8'h97, 1'b0);
    fork
      rd_byte(8'h1A, 1'b0);
      begin #3000 temp_value = 16'h2200; end
    join
    rd_byte(8'h80, 1'b1);
    i2c_stop();
    i2c_start();
    wr_byte(8'h97, 1'b0);
    rd_byte(8'h22, 1'b1);
    i2c_stop();

    // Foreign address 0x48
    d_oe = n_oe;
    i2c_start();
    wr_byte(8'h90, 1'b1);
    chk("foreign addr busy after address", 32'(busy), 1);
    wr_byte(8'h00, 1'b1);
    chk("foreign addr busy before stop", 32'(busy), 1);
    i2c_stop();
    #500;
    chk("foreign addr sda_oe cycles", 32'(n_oe - d_oe), 0);
    chk("foreign addr busy after stop", 32'(busy), 0);

    // Reset pulse while the address ack is being driven
    temp_value = 16'h1A80;
    abyte = 8'h97;
    i2c_start();
    exp_q.push_back({abyte, 1'b1});
    for (int i = 7; i >= 0; i--) send_bit(abyte[i]);
    m_sda = 1'b1;
    #120;
    chk("ack driven before reset", 32'(sda_oe), 1);
    sys_rst = 1'b0;
    #1;
    chk("sda_oe released by reset", 32'(sda_oe), 0);
    chk("busy cleared by reset", 32'(busy), 0);
    #19 sys_rst = 1'b1;
    #(Q - 140) m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
    #Q;
    i2c_stop();
    #500;
    d_done = n_done;
    i2c_start();
    wr_byte(8'h97, 1'b0);
    rd_byte(8'h1A, 1'b0);
    rd_byte(8'h80, 1'b1);
    i2c_stop();
    #500;
    chk("post-reset read rd_byte_done pulses", 32'(n_done - d_done), 2);
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
